// File: rtl/fetch_issue_queue.sv
// Fetch issue queue: turns (warp_id, pc) beats into instruction-memory reads
// and delivers the returned instructions in arrival order. Outstanding reads
// are credit-limited so the output buffer can always absorb every response.

// Circular FIFO with a registered head. The head register is loaded with the
// entry that will be at the front after this cycle's push/pop, so consumers
// see the front entry straight from a flop. The caller only pushes when
// there is room, which includes a full FIFO that is popped in the same cycle.
module fiq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_left;
    logic [W-1:0]  head_q, head_d;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Pointer/count update and next front entry
    always_comb begin
        rd_d     = pop  ? wrap_inc(rd_q) : rd_q;
        wr_d     = push ? wrap_inc(wr_q) : wr_q;
        cnt_left = cnt_q - CW'(pop);
        cnt_d    = cnt_left + CW'(push);
        if (cnt_left == '0)
            head_d = push ? wdata : head_q;
        else
            head_d = mem_q[rd_d];
    end

    // Control state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    // Storage array, no reset needed: contents are only read while counted
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata;
    end

    assign head  = head_q;
    assign count = cnt_q;
endmodule

module fetch_issue_queue #(
    parameter int PEND_DEPTH = 32,  // must hold at least one 32-beat warp batch
    parameter int OUT_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        batch_req,
    input  logic        batch_ack,
    input  logic        in_valid,
    input  logic [4:0]  in_warp_id,
    input  logic [31:0] in_pc,
    input  logic        in_last,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [4:0]  m_warp_id,
    output logic [31:0] m_pc,
    output logic [31:0] m_instr,
    output logic        m_tlast,
    output logic [31:0] err
);
    localparam int PCW  = $clog2(PEND_DEPTH + 1);
    localparam int OCW  = $clog2(OUT_DEPTH + 1);
    localparam int OCW1 = OCW + 1;

    typedef struct packed {
        logic [4:0]  warp_id;
        logic [31:0] pc;
        logic        last;
    } beat_t;

    typedef struct packed {
        beat_t       beat;
        logic [31:0] instr;
    } obeat_t;

    typedef enum logic [1:0] {IDLE, REQ, COLLECT} state_t;

    state_t        state_q, state_d;
    logic          req_vld_q, req_vld_d;
    logic [2:0]    err_q, err_d;

    beat_t         in_beat, pend_head, if_head;
    obeat_t        out_wdata, out_head;
    logic [PCW-1:0] pend_cnt, pend_cnt_nxt;
    logic [OCW-1:0] if_cnt, out_cnt;
    logic [OCW1-1:0] credit_nxt;

    logic pend_full, pend_push, req_fire, rsp_ok, out_pop;

    assign in_beat   = {in_warp_id, in_pc, in_last};
    assign pend_full = (pend_cnt == PCW'(PEND_DEPTH));
    assign req_fire  = req_vld_q && imem_req_ready;
    // A full queue still accepts a beat when its head leaves in the same cycle
    assign pend_push = in_valid && (!pend_full || req_fire);
    // Responses with nothing outstanding have no metadata to pair with
    assign rsp_ok    = imem_rsp_valid && (if_cnt != '0);
    assign m_tvalid  = (out_cnt != '0);
    assign out_pop   = m_tvalid && m_tready;
    assign out_wdata = {if_head, imem_rsp_data};

    fiq_fifo #(.W($bits(beat_t)), .DEPTH(PEND_DEPTH), .CW(PCW)) u_pend (
        .clk   (clk),
        .rst   (rst),
        .push  (pend_push),
        .pop   (req_fire),
        .wdata (in_beat),
        .head  (pend_head),
        .count (pend_cnt)
    );

    fiq_fifo #(.W($bits(beat_t)), .DEPTH(OUT_DEPTH), .CW(OCW)) u_inflight (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (rsp_ok),
        .wdata (pend_head),
        .head  (if_head),
        .count (if_cnt)
    );

    fiq_fifo #(.W($bits(obeat_t)), .DEPTH(OUT_DEPTH), .CW(OCW)) u_out (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_ok),
        .pop   (out_pop),
        .wdata (out_wdata),
        .head  (out_head),
        .count (out_cnt)
    );

    // Request valid from post-update occupancy; a stalled request is held.
    // in_flight + out_count only counts reads already issued, so keeping it
    // below OUT_DEPTH reserves an output slot for every outstanding response.
    always_comb begin
        pend_cnt_nxt = pend_cnt + PCW'(pend_push) - PCW'(req_fire);
        credit_nxt   = OCW1'(if_cnt) + OCW1'(out_cnt) + OCW1'(req_fire) - OCW1'(out_pop);
        if (req_vld_q && !imem_req_ready)
            req_vld_d = 1'b1;
        else
            req_vld_d = (pend_cnt_nxt != '0) && (credit_nxt < OCW1'(OUT_DEPTH));
    end

    // Sticky error accumulation
    always_comb begin
        err_d    = err_q;
        err_d[0] = err_q[0] | (in_valid && pend_full && !req_fire);
        err_d[1] = err_q[1] | (in_valid && (in_pc[1:0] != 2'b00));
        err_d[2] = err_q[2] | (imem_rsp_valid && (if_cnt == '0));
    end

    // Batch FSM next state; a completed handshake wins over run dropping
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run && (pend_cnt == '0)) state_d = REQ;
            REQ:     if (batch_ack) state_d = COLLECT;
                     else if (!run) state_d = IDLE;
            COLLECT: if (in_valid && in_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_vld_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_vld_q <= req_vld_d;
            err_q     <= err_d;
        end
    end

    assign batch_req      = (state_q == REQ);
    assign imem_req_valid = req_vld_q;
    assign imem_req_addr  = req_vld_q ? {pend_head.pc[31:2], 2'b00} : 32'h0;
    assign m_warp_id      = m_tvalid ? out_head.beat.warp_id : 5'h0;
    assign m_pc           = m_tvalid ? out_head.beat.pc : 32'h0;
    assign m_instr        = m_tvalid ? out_head.instr : 32'h0;
    assign m_tlast        = m_tvalid && out_head.beat.last;
    assign err            = {29'd0, err_q};
endmodule

// File: tb/tb_fetch_issue_queue.sv
// Bench for fetch_issue_queue: a sent-beat list, a delayed in-order memory
// model and an in-order delivery check against that list.
module tb_fetch_issue_queue;
    localparam int PD = 32;
    localparam int OD = 4;

    logic        clk, rst, run, batch_req, batch_ack;
    logic        in_valid, in_last;
    logic [4:0]  in_warp_id;
    logic [31:0] in_pc;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        m_tvalid, m_tready, m_tlast;
    logic [4:0]  m_warp_id;
    logic [31:0] m_pc, m_instr, err;

    fetch_issue_queue #(.PEND_DEPTH(PD), .OUT_DEPTH(OD)) dut (
        .clk(clk), .rst(rst), .run(run), .batch_req(batch_req), .batch_ack(batch_ack),
        .in_valid(in_valid), .in_warp_id(in_warp_id), .in_pc(in_pc), .in_last(in_last),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_warp_id(m_warp_id), .m_pc(m_pc), .m_instr(m_instr), .m_tlast(m_tlast),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [4:0] w; logic [31:0] pc; logic last; } ent_t;
    typedef struct { int due; logic [31:0] addr; } mrsp_t;

    ent_t  sent[$];
    mrsp_t mq[$];
    int    n_chk, n_fail, cyc_n, acc_i, pop_i, last_due;
    int    rdy_mode, trdy_mode, acc_limit, lat_lo, lat_hi;
    bit    force_rsp, req_stall_p, m_stall_p, rsp_p;
    logic [31:0] req_addr_p;
    logic [69:0] m_p;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input int mode);
        return (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
    endfunction

    // One clock: drive memory/decoder side, check, advance to next negedge
    task automatic cyc();
        bit rdy, trdy, rv, legit;
        logic [31:0] rd;
        int d;
        rv = 0; legit = 0; rd = '0;
        if (rst) begin
            mq.delete();
            req_stall_p = 0; m_stall_p = 0; rsp_p = 0;
        end else if (mq.size() > 0 && mq[0].due <= cyc_n) begin
            rv = 1; legit = 1; rd = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        if (force_rsp) begin rv = 1; rd = 32'hDEAD_BEEF; end
        rdy  = pick(rdy_mode) && (acc_i < acc_limit);
        trdy = pick(trdy_mode);
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        m_tready       = trdy;
        if (req_stall_p) begin
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_req_addr, req_addr_p);
        end
        if (m_stall_p) chk("m_hold", {m_warp_id, m_pc, m_instr, m_tlast}, m_p);
        if (rsp_p) chk("rsp_latency", m_tvalid, 1);
        chk("credit", (acc_i - pop_i) <= OD, 1);
        if (imem_req_valid && rdy) begin
            if (acc_i < sent.size()) chk("req_addr", imem_req_addr, sent[acc_i].pc & ~32'h3);
            else chk("req_extra", 1, 0);
            d = cyc_n + $urandom_range(lat_lo, lat_hi);
            if (d <= last_due) d = last_due + 1;
            mq.push_back('{due: d, addr: imem_req_addr});
            last_due = d;
            acc_i++;
        end
        if (m_tvalid && trdy) begin
            if (pop_i < sent.size())
                chk("beat", {m_warp_id, m_pc, m_instr, m_tlast},
                    {sent[pop_i].w, sent[pop_i].pc, mem_word(sent[pop_i].pc & ~32'h3), sent[pop_i].last});
            else chk("beat_extra", 1, 0);
            pop_i++;
        end
        req_stall_p = imem_req_valid && !rdy && !rst;
        req_addr_p  = imem_req_addr;
        m_stall_p   = m_tvalid && !trdy && !rst;
        m_p         = {m_warp_id, m_pc, m_instr, m_tlast};
        rsp_p       = legit;
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic clear_model();
        sent.delete(); mq.delete();
        acc_i = 0; pop_i = 0; last_due = 0;
        req_stall_p = 0; m_stall_p = 0; rsp_p = 0;
    endtask

    task automatic do_reset();
        rst = 1; run = 0; batch_ack = 0; in_valid = 0; force_rsp = 0;
        clear_model();
        repeat (3) cyc();
        rst = 0;
        cyc();
    endtask

    task automatic send_beat(input logic [4:0] w, input logic [31:0] pc, input logic last, input bit keep);
        in_valid = 1; in_warp_id = w; in_pc = pc; in_last = last;
        if (keep) sent.push_back('{w: w, pc: pc, last: last});
        cyc();
        in_valid = 0;
    endtask

    task automatic handshake();
        int t;
        run = 1; batch_ack = 1; t = 0;
        while (!batch_req && t < 20) begin cyc(); t++; end
        chk("breq_up", batch_req, 1);
        cyc();
        run = 0; batch_ack = 0;
        chk("breq_one_cycle", batch_req, 0);
    endtask

    task automatic do_batch(input int n, input int gap_max);
        handshake();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) cyc();
            send_beat(5'($urandom_range(0, 31)), $urandom() & 32'hFFFF_FFFC, i == n - 1, 1);
        end
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (pop_i < sent.size() && t < budget) begin cyc(); t++; end
        chk("drain_count", pop_i, sent.size());
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_breq"}, batch_req, 0);
        chk({tag, "_reqv"}, imem_req_valid, 0);
        chk({tag, "_addr"}, imem_req_addr, 0);
        chk({tag, "_mvalid"}, m_tvalid, 0);
        chk({tag, "_mbeat"}, {m_warp_id, m_pc, m_instr, m_tlast}, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int t;
        n_chk = 0; n_fail = 0; cyc_n = 0;
        rst = 1; run = 0; batch_ack = 0; in_valid = 0; in_warp_id = '0; in_pc = '0; in_last = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; m_tready = 0;
        force_rsp = 0; rdy_mode = 1; trdy_mode = 1; acc_limit = 1 << 30; lat_lo = 2; lat_hi = 2;
        clear_model();
        @(negedge clk);
        chk_zero_outputs("reset");
        do_reset();

        // basic three-beat batch, memory latency 2, always ready
        handshake();
        send_beat(5'd2, 32'h100, 0, 1);
        chk("req_latency", imem_req_valid, 1);
        send_beat(5'd5, 32'h200, 0, 1);
        send_beat(5'd7, 32'h300, 1, 1);
        drain(60);
        chk("basic_err", err, 0);
        // back in IDLE: a new request comes up, and dropping run withdraws it
        run = 1; t = 0;
        while (!batch_req && t < 3) begin cyc(); t++; end
        chk("idle_rereq", batch_req, 1);
        run = 0;
        cyc();
        chk("run_drop", batch_req, 0);
        cyc();
        chk("run_drop_stay", batch_req, 0);

        // full batch with decoder stalled: credit limit caps issued reads
        lat_lo = 1; lat_hi = 3; trdy_mode = 0;
        do_batch(32, 0);
        repeat (40) cyc();
        chk("credit_full", acc_i - pop_i, OD);
        chk("req_blocked", imem_req_valid, 0);
        trdy_mode = 1;
        drain(400);
        chk("full_err", err, 0);

        // random batches with random handshakes and latencies
        for (int b = 0; b < 8; b++) begin
            rdy_mode = $urandom_range(1, 2); trdy_mode = $urandom_range(1, 2);
            lat_lo = $urandom_range(1, 2); lat_hi = lat_lo + $urandom_range(0, 4);
            do_batch($urandom_range(1, 32), $urandom_range(0, 2));
            drain(2000);
        end
        chk("random_err", err, 0);
        rdy_mode = 1; trdy_mode = 1; lat_lo = 1; lat_hi = 3;

        // misaligned pc
        do_reset();
        rdy_mode = 0;
        send_beat(5'd3, 32'h102, 1, 1);
        chk("misalign_err", err, 32'h2);
        chk("misalign_valid", imem_req_valid, 1);
        chk("misalign_addr", imem_req_addr, 32'h100);
        rdy_mode = 1;
        drain(60);

        // response with nothing outstanding
        do_reset();
        force_rsp = 1;
        cyc();
        force_rsp = 0;
        chk("stray_err", err, 32'h4);
        chk("stray_no_beat", m_tvalid, 0);
        cyc();
        chk("stray_no_beat2", m_tvalid, 0);

        // pending overflow: 33 beats, nothing drains
        do_reset();
        rdy_mode = 0; trdy_mode = 0;
        for (int i = 0; i < 33; i++) begin
            send_beat(5'(i), 32'h1000 + 32'(i) * 4, i == 32, i < 32);
            if (i == 31) chk("ovf_not_yet", err, 0);
        end
        chk("ovf_err", err, 32'h1);
        rdy_mode = 1; trdy_mode = 1;
        drain(400);
        repeat (10) cyc();
        chk("ovf_retained", pop_i, 32);
        chk("ovf_no_33rd", m_tvalid, 0);

        // reset with 2 reads in flight and 3 beats pending
        do_reset();
        lat_lo = 40; lat_hi = 40; acc_limit = 2; trdy_mode = 0;
        for (int i = 0; i < 5; i++) send_beat(5'(i + 10), 32'h2000 + 32'(i) * 4, i == 4, 1);
        t = 0;
        while (acc_i < 2 && t < 20) begin cyc(); t++; end
        chk("mid_inflight", acc_i, 2);
        chk("mid_pending_valid", imem_req_valid, 1);
        rst = 1;
        #1;
        chk_zero_outputs("midrst");
        clear_model();
        acc_limit = 1 << 30; lat_lo = 1; lat_hi = 3; trdy_mode = 1;
        repeat (2) cyc();
        rst = 0;
        cyc();
        chk_zero_outputs("post_rst");
        do_batch(6, 1);
        drain(200);
        chk("post_rst_err", err, 0);
        force_rsp = 1;
        cyc();
        force_rsp = 0;
        chk("post_rst_stray", err, 32'h4);
        chk("post_rst_no_beat", m_tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/fetch_issue_queue.md
FETCH_ISSUE_QUEUE -- requirements
Module: fetch_issue_queue

Interface
REQ-001 Parameter PEND_DEPTH, default 32, SHALL set the pending (warp_id, pc) queue depth; it SHALL be at least 32, one full warp batch.
REQ-002 Parameter OUT_DEPTH, default 4, SHALL set the output instruction buffer depth and the in-flight memory credit limit.
REQ-003 Ports SHALL be, one per line: name direction width meaning.
clk  in  1  single clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
run  in  1  enables batch requests.
batch_req  out  1  request a new warp batch; drives the upstream selector's s_tvalid.
batch_ack  in  1  upstream selector's s_tready.
in_valid  in  1  one (warp_id, pc) beat; no backpressure.
in_warp_id  in  5  selected warp.
in_pc  in  32  selected pc.
in_last  in  1  final beat of the batch.
imem_req_valid  out  1  instruction memory read request.
imem_req_ready  in  1  memory accepts the request.
imem_req_addr  out  32  read address.
imem_rsp_valid  in  1  in-order response; cannot be stalled.
imem_rsp_data  in  32  instruction word.
m_tvalid  out  1  output beat valid.
m_tready  in  1  decoder accepts the beat.
m_warp_id  out  5  warp of the beat.
m_pc  out  32  pc of the beat.
m_instr  out  32  instruction.
m_tlast  out  1  last beat of the batch.
err  out  32  sticky error bits: [0] pending overflow, [1] misaligned pc, [2] unexpected response.

Function
REQ-004 The batch FSM SHALL have three states: IDLE, REQ and COLLECT.
REQ-005 In IDLE with run=1 and the pending queue empty, the FSM SHALL go to REQ on the next cycle.
REQ-006 batch_req SHALL equal 1 only in REQ; on batch_req && batch_ack the FSM SHALL go to COLLECT.
REQ-007 In COLLECT, in_valid && in_last SHALL return the FSM to IDLE.
REQ-008 If run drops while in REQ, the FSM SHALL return to IDLE.
REQ-009 Every in_valid beat SHALL be pushed into the pending queue as {warp_id, pc, last}, whatever the FSM state.
REQ-010 If in_valid arrives while the pending queue is full, the beat SHALL be dropped and err[0] set.
REQ-011 If in_pc[1:0] != 0, err[1] SHALL be set; the beat SHALL still be queued, with imem_req_addr = {pc[31:2], 2'b00}.
REQ-012 imem_req_valid SHALL be a registered output, asserted when the pending queue is non-empty and in_flight + out_count < OUT_DEPTH.
REQ-013 imem_req_valid and imem_req_addr SHALL hold stable until imem_req_ready.
REQ-014 On imem_req_valid && imem_req_ready, the head pending entry SHALL move to the in-flight metadata FIFO and in_flight SHALL increment.
REQ-015 On imem_rsp_valid, the in-flight head SHALL be popped, paired with imem_rsp_data, and pushed into the output buffer; in_flight SHALL decrement.
REQ-016 The credit rule in REQ-012 SHALL guarantee the output buffer never overflows, so no response is ever lost.
REQ-017 imem_rsp_valid with in_flight=0 SHALL be ignored and SHALL set err[2].
REQ-018 Simultaneous request accept and response in one cycle SHALL leave in_flight unchanged.
REQ-019 Simultaneous push and pop on any FIFO SHALL leave its count unchanged.
REQ-020 A simultaneous push and pop on a full FIFO SHALL be legal.
REQ-021 FIFO pointers SHALL wrap modulo depth.
REQ-022 The output port SHALL present the output buffer head; m_tvalid = (out_count != 0); a pop SHALL occur on m_tvalid && m_tready.
REQ-023 m_* outputs SHALL hold stable while m_tvalid && !m_tready.
REQ-024 Beats SHALL leave in arrival order; m_tlast SHALL equal the stored in_last.
REQ-025 Minimum latency SHALL be: in_valid at cycle t gives imem_req_valid at t+1; imem_rsp_valid at cycle r gives m_tvalid at r+1.
REQ-026 err bits SHALL be sticky until reset.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, all FIFOs empty and in_flight=0.
REQ-028 While rst=1, batch_req, imem_req_valid, m_tvalid and m_tlast SHALL be 0; imem_req_addr, m_warp_id, m_pc and m_instr SHALL be 0; err SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued and in-flight entries.
REQ-030 Responses arriving after reset release with in_flight=0 SHALL follow REQ-017.

Verification
REQ-031 Basic batch: run=1 with batch_ack=1 -> batch_req high for 1 cycle. Then 3 beats follow: (w2,0x100), (w5,0x200), (w7,0x300,last). Memory has latency 2 and always-ready. Required response: 3 m_* beats in order with matching instructions, m_tlast only on w7, and FSM back in IDLE.
REQ-032 Full batch of 32 beats with m_tready=0 -> at most OUT_DEPTH(4) imem requests outstanding. Then release m_tready -> all 32 beats delivered in order with err=0.
REQ-033 33 beats without pop and with imem_req_ready=0 -> the 33rd beat is dropped, err[0]=1 and 32 entries are retained.
REQ-034 in_pc=0x102 -> err[1]=1, imem_req_addr=0x100 and m_pc=0x102.
REQ-035 imem_rsp_valid with nothing outstanding -> err[2]=1 and no m_tvalid.
REQ-036 rst asserted while 2 entries are in flight and 3 are pending -> all outputs 0 immediately, and after release the next batch works normally.
